// File: rtl/fpu_div_iter_pkg.sv
// Shared constants and types for the iterative binary32 divider.
package fpu_div_iter_pkg;

  localparam int unsigned Q_BITS = 26;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_ROUND  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int unsigned FF_NV = 4;
  localparam int unsigned FF_DZ = 3;
  localparam int unsigned FF_OF = 2;
  localparam int unsigned FF_UF = 1;
  localparam int unsigned FF_NX = 0;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
  localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;
  localparam logic [31:0] POS_INF    = 32'h7F80_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

endpackage

// File: rtl/fpu_div_iter_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface fpu_div_iter_if;
  logic        start;
  logic        flush;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [2:0]  rm;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  fflags;

  modport master (output start, flush, opa, opb, rm,
                  input  busy, done, result, fflags);
  modport slave  (input  start, flush, opa, opb, rm,
                  output busy, done, result, fflags);
endinterface

// File: rtl/fpu_div_round.sv
// Rounds the 26-bit quotient (1.23 + guard + round), resolves overflow/underflow and packs binary32.
module fpu_div_round
  import fpu_div_iter_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp,
  input  logic [25:0]       q,
  input  logic              sticky,
  input  logic [2:0]        rm,
  output logic [31:0]       result,
  output logic [4:0]        flags
);

  logic              g, r, lsb, inexact, inc;
  logic [24:0]       mant;
  logic signed [9:0] exp_adj;
  logic [22:0]       frac;

  always_comb begin
    g       = q[1];
    r       = q[0];
    lsb     = q[2];
    inexact = g | r | sticky;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = inexact & sign;
      RM_RUP:  inc = inexact & ~sign;
      RM_RMM:  inc = g;
      default: inc = g & (r | sticky | lsb);
    endcase
    mant    = {1'b0, q[25:2]} + 25'(inc);
    exp_adj = mant[24] ? exp + 10'sd1 : exp;
    frac    = mant[24] ? mant[23:1] : mant[22:0];

    result        = {sign, exp_adj[7:0], frac};
    flags         = '0;
    flags[FF_NX]  = inexact;
    if (exp_adj >= 10'sd255) begin
      flags        = '0;
      flags[FF_OF] = 1'b1;
      flags[FF_NX] = 1'b1;
      case (rm)
        RM_RTZ:  result = {sign, MAX_FINITE[30:0]};
        RM_RDN:  result = sign ? {1'b1, POS_INF[30:0]} : MAX_FINITE;
        RM_RUP:  result = sign ? {1'b1, MAX_FINITE[30:0]} : POS_INF;
        default: result = {sign, POS_INF[30:0]};
      endcase
    end else if (exp_adj <= 10'sd0) begin
      flags        = '0;
      flags[FF_UF] = 1'b1;
      flags[FF_NX] = 1'b1;
      result       = {sign, 31'd0};
    end
  end

endmodule

// File: rtl/fpu_div_iter.sv
// Multi-cycle radix-2 restoring FDIV.S with start/busy/done handshake, flush and RISC-V fflags.
module fpu_div_iter
  import fpu_div_iter_pkg::*;
#(
  parameter int unsigned STEPS_PER_CYCLE = 1
)
(
  input logic           clk,
  input logic           rst,
  fpu_div_iter_if.slave bus
);

  localparam int unsigned N_CYC = Q_BITS / STEPS_PER_CYCLE;
  localparam int unsigned CNT_W = 5;

  if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2 &&
      STEPS_PER_CYCLE != 13 && STEPS_PER_CYCLE != 26) begin : g_bad_steps
    $error("fpu_div_iter: STEPS_PER_CYCLE must be 1, 2, 13 or 26");
  end

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              sign;
  logic signed [9:0] exp_q;
  logic [23:0]       mb;
  logic [24:0]       rem;
  logic [25:0]       q;
  logic [2:0]        rm_q;

  fp32_t a, b;
  logic  a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, sgn_c;
  logic  accept_c, special_c;
  logic [31:0] spec_res_c, rnd_res_c;
  logic [4:0]  spec_flags_c, rnd_flags_c;

  assign a = fp32_t'(bus.opa);
  assign b = fp32_t'(bus.opb);

  // Operand classification; exponent 0 reads as zero (denormals-are-zero).
  assign a_nan  = (a.exp == 8'hFF) && (a.frac != 23'd0);
  assign b_nan  = (b.exp == 8'hFF) && (b.frac != 23'd0);
  assign a_snan = a_nan && !a.frac[22];
  assign b_snan = b_nan && !b.frac[22];
  assign a_inf  = (a.exp == 8'hFF) && (a.frac == 23'd0);
  assign b_inf  = (b.exp == 8'hFF) && (b.frac == 23'd0);
  assign a_zero = (a.exp == 8'd0);
  assign b_zero = (b.exp == 8'd0);
  assign sgn_c  = a.sign ^ b.sign;

  assign accept_c = bus.start && !bus.flush && (state == S_IDLE || state == S_DONE);

  always_comb begin : special_resolve
    special_c    = 1'b1;
    spec_res_c   = '0;
    spec_flags_c = '0;
    if (a_nan || b_nan) begin
      spec_res_c          = CANON_NAN;
      spec_flags_c[FF_NV] = a_snan | b_snan;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res_c          = CANON_NAN;
      spec_flags_c[FF_NV] = 1'b1;
    end else if (a_inf) begin
      spec_res_c = {sgn_c, POS_INF[30:0]};
    end else if (b_zero) begin
      spec_res_c          = {sgn_c, POS_INF[30:0]};
      spec_flags_c[FF_DZ] = 1'b1;
    end else if (b_inf || a_zero) begin
      spec_res_c = {sgn_c, 31'd0};
    end else begin
      special_c = 1'b0;
    end
  end

  // Pre-normalise so the quotient lands in [1,2).
  logic [23:0]       ma_c, mb_c;
  logic              ma_lt_c;
  logic signed [9:0] exp0_c, exp_init_c;
  logic [24:0]       rem0_c;

  assign ma_c       = {1'b1, a.frac};
  assign mb_c       = {1'b1, b.frac};
  assign ma_lt_c    = ma_c < mb_c;
  assign exp0_c     = 10'(a.exp) - 10'(b.exp) + 10'd127;
  assign exp_init_c = ma_lt_c ? exp0_c - 10'sd1 : exp0_c;
  assign rem0_c     = ma_lt_c ? {ma_c, 1'b0} : {1'b0, ma_c};

  logic [STEPS_PER_CYCLE:0][24:0] rem_chain;
  logic [STEPS_PER_CYCLE-1:0]     qbits;

  assign rem_chain[0] = rem;
  for (genvar gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
    logic        ge;
    logic [24:0] diff;
    assign ge                  = rem_chain[gi] >= {1'b0, mb};
    assign diff                = ge ? rem_chain[gi] - {1'b0, mb} : rem_chain[gi];
    assign rem_chain[gi+1]     = 25'(diff << 1);
    assign qbits[STEPS_PER_CYCLE-1-gi] = ge;
  end

  fpu_div_round u_round (
    .sign   (sign),
    .exp    (exp_q),
    .q      (q),
    .sticky (|rem),
    .rm     (rm_q),
    .result (rnd_res_c),
    .flags  (rnd_flags_c)
  );

  always_ff @(posedge clk) begin : state_reg
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin : next_state
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          state_nxt = S_IDLE;
          if (bus.start) state_nxt = special_c ? S_DONE : S_DIVIDE;
        end
        S_DIVIDE: if (cnt == CNT_W'(N_CYC - 1)) state_nxt = S_ROUND;
        S_ROUND:  state_nxt = S_DONE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath and registered outputs; result/fflags only move on entry to DONE.
  always_ff @(posedge clk) begin : datapath
    if (rst) begin
      cnt        <= '0;
      sign       <= 1'b0;
      exp_q      <= '0;
      mb         <= '0;
      rem        <= '0;
      q          <= '0;
      rm_q       <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.fflags <= '0;
    end else begin
      bus.busy <= (state_nxt == S_DIVIDE) || (state_nxt == S_ROUND);
      bus.done <= (state_nxt == S_DONE);
      if (accept_c && !special_c) begin
        sign  <= sgn_c;
        exp_q <= exp_init_c;
        mb    <= mb_c;
        rem   <= rem0_c;
        q     <= '0;
        rm_q  <= bus.rm;
        cnt   <= '0;
      end else if (state == S_DIVIDE && !bus.flush) begin
        rem <= rem_chain[STEPS_PER_CYCLE];
        q   <= 26'({q, qbits});
        cnt <= cnt + CNT_W'(1);
      end
      if (accept_c && special_c) begin
        bus.result <= spec_res_c;
        bus.fflags <= spec_flags_c;
      end else if (state == S_ROUND && !bus.flush) begin
        bus.result <= rnd_res_c;
        bus.fflags <= rnd_flags_c;
      end
    end
  end

endmodule

// File: tb/tb_fpu_div_iter.sv
// Directed bench for fpu_div_iter: integer-division reference model plus per-done scoreboard.
module tb_fpu_div_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_div_iter_if bus1();
  fpu_div_iter_if bus2();

  fpu_div_iter #(.STEPS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  fpu_div_iter #(.STEPS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference: one exact integer division of the significands, then IEEE rounding by mode.
  function automatic logic [36:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] m);
    bit s, an, bn, asn, bsn, ai, bi, az, bz, g, r, st, inx, inc;
    int ea, eb, e;
    longint ma, mb, num, qq, mant;
    logic [31:0] res;
    logic [4:0]  fl;
    s   = a[31] ^ b[31];
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    an  = (ea == 255) && (a[22:0] != 23'd0);
    bn  = (eb == 255) && (b[22:0] != 23'd0);
    asn = an && !a[22];
    bsn = bn && !b[22];
    ai  = (ea == 255) && (a[22:0] == 23'd0);
    bi  = (eb == 255) && (b[22:0] == 23'd0);
    az  = (ea == 0);
    bz  = (eb == 0);
    if (an || bn) return {((asn || bsn) ? 5'h10 : 5'h00), 32'h7FC00000};
    if ((az && bz) || (ai && bi)) return {5'h10, 32'h7FC00000};
    if (ai) return {5'h00, s, 31'h7F800000};
    if (bz) return {5'h08, s, 31'h7F800000};
    if (bi || az) return {5'h00, s, 31'h0};
    ma = 64'h800000 | longint'(a[22:0]);
    mb = 64'h800000 | longint'(b[22:0]);
    e  = ea - eb + 127;
    if (ma < mb) begin
      ma = ma * 2;
      e  = e - 1;
    end
    num  = ma << 25;
    qq   = num / mb;
    st   = (num % mb) != 0;
    mant = qq / 4;
    g    = ((qq / 2) % 2) == 1;
    r    = (qq % 2) == 1;
    inx  = g || r || st;
    case (m)
      3'd1:    inc = 1'b0;
      3'd2:    inc = inx && s;
      3'd3:    inc = inx && !s;
      3'd4:    inc = g;
      default: inc = g && (r || st || ((mant % 2) == 1));
    endcase
    mant = mant + (inc ? 64'd1 : 64'd0);
    if (mant == (64'd1 << 24)) begin
      mant = mant / 2;
      e    = e + 1;
    end
    if (e >= 255) begin
      fl = 5'h05;
      case (m)
        3'd1:    res = {s, 31'h7F7FFFFF};
        3'd2:    res = s ? 32'hFF800000 : 32'h7F7FFFFF;
        3'd3:    res = s ? 32'hFF7FFFFF : 32'h7F800000;
        default: res = {s, 31'h7F800000};
      endcase
    end else if (e <= 0) begin
      fl  = 5'h03;
      res = {s, 31'h0};
    end else begin
      fl  = {4'h0, inx};
      res = {s, e[7:0], mant[22:0]};
    end
    return {fl, res};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus1.done === 1'b1) begin
      if (q1.size() == 0) chk("dut1_unexpected_done", 37'(bus1.done), 37'(0));
      else begin
        e1 = q1.pop_front();
        chk("dut1_result", {bus1.fflags, bus1.result}, {e1.fl, e1.res});
      end
    end
    if (bus2.done === 1'b1) begin
      if (q2.size() == 0) chk("dut2_unexpected_done", 37'(bus2.done), 37'(0));
      else begin
        e2 = q2.pop_front();
        chk("dut2_result", {bus2.fflags, bus2.result}, {e2.fl, e2.res});
      end
    end
  end

  // Issue one op (called right after a negedge) and check latency and busy span.
  task automatic run_op(input int sel, input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] m,
                        input logic [31:0] lit_res, input logic [4:0] lit_fl,
                        input bit special);
    logic [36:0] mdl;
    exp_t e;
    int   n, busy_n, lat;
    bit   got;
    mdl = model_div(a, b, m);
    chk({tag, "_model"}, mdl, {lit_fl, lit_res});
    e.res = mdl[31:0];
    e.fl  = mdl[36:32];
    lat   = special ? 1 : ((sel == 0) ? 28 : 15);
    if (sel == 0) begin
      q1.push_back(e);
      bus1.opa = a; bus1.opb = b; bus1.rm = m; bus1.start = 1'b1;
    end else begin
      q2.push_back(e);
      bus2.opa = a; bus2.opb = b; bus2.rm = m; bus2.start = 1'b1;
    end
    n = 0; busy_n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      bus1.start = 1'b0;
      bus2.start = 1'b0;
      if ((sel == 0) ? bus1.done : bus2.done) got = 1'b1;
      else if ((sel == 0) ? bus1.busy : bus2.busy) busy_n++;
    end
    chk({tag, "_latency"}, 37'(n), 37'(lat));
    chk({tag, "_busy_cycles"}, 37'(busy_n), 37'(lat - 1));
  endtask

  int dn;

  initial begin
    rst = 1'b1;
    bus1.start = 1'b0; bus1.flush = 1'b0; bus1.opa = '0; bus1.opb = '0; bus1.rm = '0;
    bus2.start = 1'b0; bus2.flush = 1'b0; bus2.opa = '0; bus2.opb = '0; bus2.rm = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_dut1", {30'(0), bus1.busy, bus1.done, bus1.fflags}, 37'(0));
    chk("reset_dut1_result", 37'(bus1.result), 37'(0));
    chk("reset_dut2", {30'(0), bus2.busy, bus2.done, bus2.fflags}, 37'(0));

    run_op(0, "six_half",   32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'h00, 1'b0);
    run_op(0, "third_rne",  32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'h01, 1'b0);
    run_op(0, "third_rtz",  32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 5'h01, 1'b0);
    run_op(0, "third_rup",  32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 5'h01, 1'b0);
    run_op(0, "third_rdn",  32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 5'h01, 1'b0);
    run_op(0, "nthird_rdn", 32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 5'h01, 1'b0);
    run_op(0, "div_zero",   32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 5'h08, 1'b1);
    run_op(0, "zero_zero",  32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 5'h10, 1'b1);
    run_op(0, "snan",       32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'h10, 1'b1);
    run_op(0, "qnan",       32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'h00, 1'b1);
    run_op(0, "ninf_two",   32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 5'h00, 1'b1);
    run_op(0, "two_inf",    32'h40000000, 32'h7F800000, 3'd0, 32'h00000000, 5'h00, 1'b1);
    run_op(0, "ovf_rne",    32'h7F7FFFFF, 32'h3F000000, 3'd0, 32'h7F800000, 5'h05, 1'b0);
    run_op(0, "ovf_rtz",    32'h7F7FFFFF, 32'h3F000000, 3'd1, 32'h7F7FFFFF, 5'h05, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_after_done", {bus1.fflags, bus1.result}, {5'h05, 32'h7F7FFFFF});
    chk("done_single_pulse", 37'(bus1.done), 37'(0));
    run_op(0, "underflow",  32'h00800000, 32'h40000000, 3'd0, 32'h00000000, 5'h03, 1'b0);
    run_op(0, "pre_flush",  32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'h01, 1'b0);

    // Flush in DIVIDE cycle 5 of a back-to-back start.
    bus1.opa = 32'h40C00000; bus1.opb = 32'h40000000; bus1.rm = 3'd0; bus1.start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      bus1.start = 1'b0;
    end
    chk("flush_pre_busy", 37'(bus1.busy), 37'(1));
    bus1.flush = 1'b1;
    @(negedge clk);
    bus1.flush = 1'b0;
    chk("flush_idle", 37'(bus1.busy), 37'(0));
    chk("flush_hold", {bus1.fflags, bus1.result}, {5'h01, 32'h3EAAAAAB});
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus1.done) dn++;
    end
    chk("flush_no_done", 37'(dn), 37'(0));

    // start together with flush is dropped.
    bus1.start = 1'b1; bus1.flush = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0; bus1.flush = 1'b0;
    chk("drop_busy", 37'(bus1.busy), 37'(0));
    dn = 0;
    repeat (35) begin
      @(negedge clk);
      if (bus1.done || bus1.busy) dn++;
    end
    chk("drop_no_activity", 37'(dn), 37'(0));

    // Reset in the middle of DIVIDE clears everything.
    bus1.start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      bus1.start = 1'b0;
    end
    chk("rst_pre_busy", 37'(bus1.busy), 37'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_flags", {30'(0), bus1.busy, bus1.done, bus1.fflags}, 37'(0));
    chk("rst_mid_result", 37'(bus1.result), 37'(0));

    run_op(0, "after_rst",  32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'h00, 1'b0);
    run_op(1, "s2_six_half", 32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'h00, 1'b0);
    run_op(1, "s2_third",    32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'h01, 1'b0);

    repeat (3) @(negedge clk);
    chk("dut1_queue_empty", 37'(q1.size()), 37'(0));
    chk("dut2_queue_empty", 37'(q2.size()), 37'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
